// File: rtl/serial_add_pkg.sv
// Shared types and helpers for the bit-serial adder sequencer.
package serial_add_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Bit-counter width that can hold the value WIDTH
  function automatic int unsigned cnt_width(input int unsigned width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/fa.sv
// One-bit full-adder primitive.
module fa (
  input  logic A,
  input  logic B,
  input  logic CI,
  output logic S,
  output logic CO
);

  assign S  = A ^ B ^ CI;
  assign CO = (A & B) | (CI & (A ^ B));

endmodule

// File: rtl/serial_add_seq.sv
// Bit-serial adder: one fa reused LSB-first, one bit per clock, valid/ready on both sides.
// Optional subtract mode (SUB port) is enabled by defining SERIAL_ADD_SUB_EN.
module serial_add_seq
  import serial_add_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             C,
  input  logic             R,
  input  logic             IN_VALID,
  output logic             IN_READY,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             CI,
`ifdef SERIAL_ADD_SUB_EN
  input  logic             SUB,
`endif
  output logic             OUT_VALID,
  input  logic             OUT_READY,
  output logic [WIDTH-1:0] S,
  output logic             CO
);

  localparam int unsigned CNT_W = cnt_width(WIDTH);

  state_t             state;
  state_t             state_nxt;
  logic [WIDTH-1:0]   a_sh;
  logic [WIDTH-1:0]   b_sh;
  logic [WIDTH-1:0]   sum;
  logic [WIDTH-1:0]   sum_shift;
  logic [CNT_W-1:0]   cnt;
  logic               carry;
  logic               co_q;
  logic               fa_s;
  logic               fa_co;
  logic               load;
  logic               step;
  logic               last;
  logic [WIDTH-1:0]   b_load;
  logic               carry_load;

  fa u_fa (
    .A  (a_sh[0]),
    .B  (b_sh[0]),
    .CI (carry),
    .S  (fa_s),
    .CO (fa_co)
  );

  // Operand capture: subtract inverts B on the way in and forces carry-in to 1
`ifdef SERIAL_ADD_SUB_EN
  assign b_load     = B ^ {WIDTH{SUB}};
  assign carry_load = SUB | CI;
`else
  assign b_load     = B;
  assign carry_load = CI;
`endif

  always_ff @(posedge C or posedge R) begin
    if (R) state <= IDLE;
    else   state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    step      = 1'b0;
    last      = (cnt == CNT_W'(WIDTH - 1));
    sum_shift = sum >> 1;
    sum_shift[WIDTH-1] = fa_s;
    case (state)
      IDLE: begin
        load = IN_VALID;
        if (IN_VALID) state_nxt = RUN;
      end
      RUN: begin
        step = 1'b1;
        if (last) state_nxt = DONE;
      end
      DONE: begin
        if (OUT_READY) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Serial datapath: shift operands out, sum bits in at the MSB
  always_ff @(posedge C or posedge R) begin
    if (R) begin
      a_sh  <= '0;
      b_sh  <= '0;
      sum   <= '0;
      cnt   <= '0;
      carry <= 1'b0;
      co_q  <= 1'b0;
    end else if (load) begin
      a_sh  <= A;
      b_sh  <= b_load;
      carry <= carry_load;
      cnt   <= '0;
    end else if (step) begin
      a_sh  <= a_sh >> 1;
      b_sh  <= b_sh >> 1;
      sum   <= sum_shift;
      carry <= fa_co;
      cnt   <= cnt + CNT_W'(1);
      if (last) co_q <= fa_co;
    end
  end

  assign IN_READY  = (state == IDLE);
  assign OUT_VALID = (state == DONE);
  assign S         = sum;
  assign CO        = co_q;

endmodule

// File: tb/tb_serial_add_seq.sv
// Directed self-checking bench for serial_add_seq (WIDTH=8).
module tb_serial_add_seq;

  localparam int unsigned W = 8;

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         ci;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] s;
  logic         co;
`ifdef SERIAL_ADD_SUB_EN
  logic         sub;
`endif

  int n_cmp;
  int n_fail;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         ci;
    logic [W-1:0] exp_s;
    logic         exp_co;
  } vec_t;

  vec_t vecs[8];

  serial_add_seq #(.WIDTH(W)) dut (
    .C         (clk),
    .R         (rst),
    .IN_VALID  (in_valid),
    .IN_READY  (in_ready),
    .A         (a),
    .B         (b),
    .CI        (ci),
`ifdef SERIAL_ADD_SUB_EN
    .SUB       (sub),
`endif
    .OUT_VALID (out_valid),
    .OUT_READY (out_ready),
    .S         (s),
    .CO        (co)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Offer one operand word for a single cycle, wait for the result, check latency
  task automatic start_and_wait(input logic [W-1:0] av, input logic [W-1:0] bv, input logic civ,
                                input string name);
    int n;
    a = av; b = bv; ci = civ; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    check({name, " in_ready_drop"}, 64'(in_ready), 64'd0);
    n = 0;
    while (!out_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    check({name, " latency"}, 64'(n), 64'(W));
  endtask

  initial begin
    int n;
    logic [W-1:0] s_hold;
    logic         co_hold;
    n_cmp = 0; n_fail = 0;
    rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; ci = 1'b0; out_ready = 1'b0;
`ifdef SERIAL_ADD_SUB_EN
    sub = 1'b0;
`endif

    vecs[0] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1};
    vecs[1] = '{8'h5A, 8'h3C, 1'b1, 8'h97, 1'b0};
    vecs[2] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1};
    vecs[3] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};
    vecs[4] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0};
    vecs[5] = '{8'hA5, 8'h5A, 1'b0, 8'hFF, 1'b0};
    vecs[6] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0};
    vecs[7] = '{8'h00, 8'h00, 1'b1, 8'h01, 1'b0};

    #2;
    check("rst in_ready", 64'(in_ready), 64'd1);
    check("rst out_valid", 64'(out_valid), 64'd0);
    check("rst s", 64'(s), 64'd0);
    check("rst co", 64'(co), 64'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Table: OUT_READY held high, result valid for exactly one cycle
    out_ready = 1'b1;
    foreach (vecs[i]) begin
      start_and_wait(vecs[i].a, vecs[i].b, vecs[i].ci, $sformatf("vec%0d", i));
      check($sformatf("vec%0d s", i), 64'(s), 64'(vecs[i].exp_s));
      check($sformatf("vec%0d co", i), 64'(co), 64'(vecs[i].exp_co));
      @(negedge clk);
      check($sformatf("vec%0d valid_1cyc", i), 64'(out_valid), 64'd0);
      check($sformatf("vec%0d in_ready_back", i), 64'(in_ready), 64'd1);
    end

    // Back-pressure in DONE
    out_ready = 1'b0;
    start_and_wait(8'h12, 8'h34, 1'b0, "bp");
    s_hold = s; co_hold = co;
    check("bp s", 64'(s), 64'h46);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("bp hold valid", 64'(out_valid), 64'd1);
      check("bp hold s", 64'(s), 64'(s_hold));
      check("bp hold co", 64'(co), 64'(co_hold));
      check("bp hold in_ready", 64'(in_ready), 64'd0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    check("bp release in_ready", 64'(in_ready), 64'd1);
    check("bp release valid", 64'(out_valid), 64'd0);

    // IN_VALID held during RUN with different operands: ignored until IDLE
    a = 8'h01; b = 8'h01; ci = 1'b0; in_valid = 1'b1;
    @(negedge clk);
    a = 8'h11; b = 8'h22;
    n = 0;
    while (!out_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("hold first latency", 64'(n), 64'(W));
    check("hold first s", 64'(s), 64'h02);
    @(negedge clk);
    check("hold idle in_ready", 64'(in_ready), 64'd1);
    @(negedge clk);
    in_valid = 1'b0;
    check("hold second accepted", 64'(in_ready), 64'd0);
    n = 0;
    while (!out_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("hold second latency", 64'(n), 64'(W));
    check("hold second s", 64'(s), 64'h33);
    check("hold second co", 64'(co), 64'd0);
    @(negedge clk);

    // Asynchronous reset mid-RUN aborts the operation
    a = 8'hF0; b = 8'h0F; ci = 1'b1; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (4) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("abort in_ready", 64'(in_ready), 64'd1);
    check("abort out_valid", 64'(out_valid), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    n = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (out_valid) n++;
    end
    check("abort no result", 64'(n), 64'd0);
    start_and_wait(8'h5A, 8'h3C, 1'b1, "post_abort");
    check("post_abort s", 64'(s), 64'h97);
    check("post_abort co", 64'(co), 64'd0);
    @(negedge clk);

`ifdef SERIAL_ADD_SUB_EN
    // Subtract mode
    sub = 1'b1;
    start_and_wait(8'h10, 8'h01, 1'b0, "sub1");
    check("sub1 s", 64'(s), 64'h0F);
    check("sub1 co", 64'(co), 64'd1);
    @(negedge clk);
    start_and_wait(8'h00, 8'h01, 1'b0, "sub2");
    check("sub2 s", 64'(s), 64'hFF);
    check("sub2 co", 64'(co), 64'd0);
    @(negedge clk);
    sub = 1'b0;
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/serial_add_seq.md
Name: serial_add_seq

Overview:
Sequencer that time-multiplexes one `fa` full-adder primitive to add two WIDTH-bit operands bit-serially, LSB first, one bit per clock. The carry is held in a flop between bits. A valid/ready handshake sits on both the input side and the output side. It is the area-minimal adder option in najaeda benchmark netlists, built only from `fa`, `mux2` and flops.

Parameters:
WIDTH  8  operand/result width in bits; legal range 1..64
CNT_W  $clog2(WIDTH+1)  bit-counter width; derived, not overridable

Ports:
C  input  1  clock, rising edge
R  input  1  reset, asynchronous, active-high
IN_VALID  input  1  operand word offered
IN_READY  output  1  block can accept operands
A  input  WIDTH  operand A
B  input  WIDTH  operand B
CI  input  1  carry-in
OUT_VALID  output  1  result available
OUT_READY  input  1  consumer accepts result
S  output  WIDTH  sum
CO  output  1  final carry-out

Behaviour:
- Clock is C. Reset R is asynchronous and active-high.
- States: IDLE, RUN, DONE. While R=1 the block forces IDLE, cnt=0, carry=0, sum=0, OUT_VALID=0, S=0, CO=0.
- IN_READY = (state==IDLE). It is combinational from state, so it reads 1 during and right after reset.
- OUT_VALID = (state==DONE). It is registered via state.
- IDLE, when IN_VALID=1 at an edge:
  - Capture A and B into shift registers; carry<=CI; cnt<=0.
  - Go to RUN.
  - With IN_VALID=0, stay in IDLE.
- RUN, on each edge:
  - The `fa` takes a_sh[0], b_sh[0] and carry.
  - Shift a_sh and b_sh right by 1.
  - Shift fa.S into sum at the MSB (sum <= {fa.S, sum[WIDTH-1:1]}).
  - carry<=fa.CO; cnt<=cnt+1.
  - On the edge where cnt==WIDTH-1, go to DONE and latch CO<=fa.CO.
- Latency: OUT_VALID rises exactly WIDTH edges after the accepting edge.
- DONE:
  - Hold S and CO stable.
  - When OUT_READY=1 at an edge, go to IDLE.
  - Minimum initiation interval is WIDTH+2 cycles.
- S is driven from the sum register. S and CO are meaningful only while OUT_VALID=1; during RUN, S shows partial shift contents.
- IN_VALID, A, B and CI are ignored outside IDLE. Nothing is queued.
- OUT_READY is ignored outside DONE.
- Reset asserted mid-RUN or in DONE:
  - The operation is aborted.
  - No OUT_VALID pulse is produced.
  - The block resumes in IDLE after R deasserts.
- WIDTH=1: RUN lasts one edge; the DONE transition happens with cnt==0.
- Arithmetic: {CO,S} = A + B + CI, modulo 2^(WIDTH+1). There is no saturation.

Optional Feature:
Macro: SERIAL_ADD_SUB_EN
- With the macro:
  - Extra input port SUB (1 bit), sampled with the operands in IDLE.
  - When SUB=1, capture ~B and force carry<=1, ignoring CI, so {CO,S} = A + ~B + 1 = A - B.
  - CO=1 means no borrow.
  - The B inversion is implemented with a `mux2` per bit or an XOR on capture.
- Without the macro: the SUB port does not exist and behaviour is as above.

Decomposition:
- Shared package serial_add_pkg:
  - state typedef (IDLE=2'd0, RUN=2'd1, DONE=2'd2).
  - Localparam function computing CNT_W.
- No new sub-module. Instantiate the existing `fa` primitive once as the datapath.

Test Plan:
1. WIDTH=8, A=8'hFF, B=8'h01, CI=0, IN_VALID for one cycle:
   - IN_READY drops the next cycle.
   - OUT_VALID rises 8 edges after acceptance with S=8'h00, CO=1.
2. A=8'h5A, B=8'h3C, CI=1, OUT_READY held 1:
   - S=8'h97, CO=0.
   - OUT_VALID high for exactly 1 cycle.
   - IN_READY returns 1 the following cycle.
3. Back-pressure: OUT_READY=0 for 5 cycles in DONE:
   - OUT_VALID, S and CO stay constant.
   - IN_READY stays 0.
   - Raising OUT_READY returns the block to IDLE after one edge.
4. IN_VALID held with new operands (8'h11+8'h22) throughout RUN of 8'h01+8'h01:
   - First result is S=8'h02.
   - Second operation starts only from IDLE and yields 8'h33.
5. Assert R asynchronously (between edges) after the 4th RUN edge:
   - IN_READY=1 and OUT_VALID=0 immediately.
   - No result is emitted.
   - A new operation afterwards completes correctly.
6. SERIAL_ADD_SUB_EN defined, SUB=1:
   - 8'h10-8'h01 gives S=8'h0F, CO=1.
   - 8'h00-8'h01 gives S=8'hFF, CO=0.
